// File: rtl/mips32_prog_loader.sv
// Boot-time program/data loader for the mips32 core.
// Consumes a header/payload word stream over valid/ready, writes instruction
// and data memory images through one write port, then hands the core its
// initial PC and raises cpu_run.
// Optional build macro: MIPS32_LOADER_CHECKSUM_EN adds a per-section XOR
// checksum word (state CHK) and the ERR/load_err path.
module mips32_prog_loader #(
   parameter int ADDR_W = 10,   // memory word-address width (must be <= 16)
   parameter int CNT_W  = 14    // section word-count width (must be <= 14)
) (
   input  logic              clkP,
   input  logic              rstN,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [31:0]       cpu_pc_init,
   output logic              cpu_run,
   output logic              load_err,
   output logic [15:0]       words_loaded
);

   typedef enum logic [2:0] {
      S_HDR  = 3'd0,
      S_DATA = 3'd1,
      S_CHK  = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                w_acc;
   logic                w_hdr_end;
   logic                w_hdr_sel;
   logic [CNT_W-1:0]    w_hdr_cnt;
   logic [15:0]         w_hdr_base;

   logic                r_sel;
   logic [ADDR_W-1:0]   r_addr;
   logic [CNT_W-1:0]    r_remaining;
   logic [15:0]         r_words;
   logic                r_mem_we;
   logic                r_mem_sel;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wdata;
   logic [31:0]         r_pc_init;

   // Header field decode; only meaningful while in S_HDR
   assign w_hdr_end  = in_data[31];
   assign w_hdr_sel  = in_data[30];
   assign w_hdr_cnt  = in_data[16 +: CNT_W];
   assign w_hdr_base = in_data[15:0];
   assign w_acc      = in_valid && in_ready;

`ifdef MIPS32_LOADER_CHECKSUM_EN
   logic [31:0] r_xor;

   // XOR of the current section's payload; cleared by every accepted header
   always_ff @(posedge clkP or negedge rstN) begin
      if (!rstN) begin
         r_xor <= 32'd0;
      end else if (w_acc && r_state == S_HDR) begin
         r_xor <= 32'd0;
      end else if (w_acc && r_state == S_DATA) begin
         r_xor <= r_xor ^ in_data;
      end
   end
`endif

   // State register
   always_ff @(posedge clkP or negedge rstN) begin
      if (!rstN) begin
         r_state <= S_HDR;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_HDR: begin
            if (w_acc) begin
               if (w_hdr_end) begin
                  w_state_next = S_DONE;
               end else if (w_hdr_cnt != '0) begin
                  w_state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (w_acc && r_remaining == CNT_W'(1)) begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
               w_state_next = S_CHK;
`else
               w_state_next = S_HDR;
`endif
            end
         end
         S_CHK: begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
            if (w_acc) begin
               w_state_next = (in_data == r_xor) ? S_HDR : S_ERR;
            end
`else
            w_state_next = S_HDR;
`endif
         end
         default: begin
            // DONE and ERR are terminal until reset
            w_state_next = r_state;
         end
      endcase
   end

   // State-decoded outputs
   always_comb begin
      in_ready = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CHK);
      cpu_run  = (r_state == S_DONE);
`ifdef MIPS32_LOADER_CHECKSUM_EN
      load_err = (r_state == S_ERR);
`else
      load_err = 1'b0;
`endif
   end

   // Section context, write port registers, PC latch and payload counter
   always_ff @(posedge clkP or negedge rstN) begin
      if (!rstN) begin
         r_sel       <= 1'b0;
         r_addr      <= '0;
         r_remaining <= '0;
         r_words     <= 16'd0;
         r_mem_we    <= 1'b0;
         r_mem_sel   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'd0;
         r_pc_init   <= 32'd0;
      end else begin
         r_mem_we <= 1'b0;
         if (w_acc && r_state == S_HDR) begin
            if (w_hdr_end) begin
               r_pc_init <= {16'd0, w_hdr_base};
            end else begin
               r_sel       <= w_hdr_sel;
               r_addr      <= w_hdr_base[ADDR_W-1:0];
               r_remaining <= w_hdr_cnt;
            end
         end else if (w_acc && r_state == S_DATA) begin
            r_mem_we    <= 1'b1;
            r_mem_sel   <= r_sel;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= in_data;
            r_addr      <= r_addr + ADDR_W'(1);   // wraps modulo 2^ADDR_W
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_words != 16'hFFFF) begin
               r_words <= r_words + 16'd1;
            end
         end
      end
   end

   assign mem_we       = r_mem_we;
   assign mem_sel      = r_mem_sel;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign cpu_pc_init  = r_pc_init;
   assign words_loaded = r_words;

endmodule
